// File: rtl/grev_pipe.sv
// Two-stage pipelined generalized bit-reverse / or-combine unit (GREV / GORC).
// Stage A applies butterfly stages 0..2 to the incoming operand. Stage B
// applies the remaining stages and holds the result for the consumer.
// Both stages use valid/ready handshakes, so a full pipeline can still
// accept one operation per cycle. Legal XLEN values are 32 and 64.
module grev_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    localparam int SW   = (XLEN == 64) ? 6 : 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [SW-1:0]    in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rd,
    output logic [TAG_W-1:0] out_tag
);

    // Number of butterfly stages left for pipeline stage B.
    localparam int HI_W = SW - 3;

    // One butterfly stage k. Bit i of mask M_k is set when bit k of i is clear,
    // which gives 0x55.., 0x33.., 0x0F.., and so on. GORC ORs the swapped
    // value into x; GREV replaces x with it.
    function automatic logic [XLEN-1:0] butterfly(
        input logic [XLEN-1:0] x,
        input int              k,
        input logic            gorc,
        input logic            en
    );
        logic [XLEN-1:0] m;
        logic [XLEN-1:0] s;
        for (int i = 0; i < XLEN; i++) begin
            m[i] = (((i >> k) & 1) == 0);
        end
        s = ((x & m) << (1 << k)) | ((x & ~m) >> (1 << k));
        if (!en) begin
            return x;
        end
        return gorc ? (x | s) : s;
    endfunction

    // Stage A state.
    logic             valid_a_reg;
    logic             op_a_reg;
    logic [XLEN-1:0]  x_a_reg;
    logic [HI_W-1:0]  hi_a_reg;
    logic [TAG_W-1:0] tag_a_reg;

    // Stage B (output) state.
    logic             out_valid_reg;
    logic [XLEN-1:0]  out_rd_reg;
    logic [TAG_W-1:0] out_tag_reg;

    // Combinational butterfly chains feeding each stage register.
    logic [3:0][XLEN-1:0]    a_chain;
    logic [HI_W:0][XLEN-1:0] b_chain;

    logic adv_b;

    // Stage B may load whenever it is empty or its result leaves this cycle.
    assign adv_b    = !out_valid_reg || out_ready;
    assign in_ready = !valid_a_reg || adv_b;

    assign a_chain[0] = in_rs1;
    assign b_chain[0] = x_a_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage_a
            assign a_chain[gi+1] = butterfly(a_chain[gi], gi, in_op, in_rs2[gi]);
        end
        for (gi = 0; gi < HI_W; gi++) begin : g_stage_b
            assign b_chain[gi+1] = butterfly(b_chain[gi], gi + 3, op_a_reg, hi_a_reg[gi]);
        end
    endgenerate

    // Stage A: capture a new operation (or a bubble) whenever it can advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_a_reg <= 1'b0;
            op_a_reg    <= 1'b0;
            x_a_reg     <= '0;
            hi_a_reg    <= '0;
            tag_a_reg   <= '0;
        end else if (in_ready) begin
            valid_a_reg <= in_valid;
            if (in_valid) begin
                op_a_reg  <= in_op;
                x_a_reg   <= a_chain[3];
                hi_a_reg  <= in_rs2[SW-1:3];
                tag_a_reg <= in_tag;
            end
        end
    end

    // Stage B: take stage A's result on advance; hold it while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_rd_reg    <= '0;
            out_tag_reg   <= '0;
        end else if (adv_b) begin
            out_valid_reg <= valid_a_reg;
            if (valid_a_reg) begin
                out_rd_reg  <= b_chain[HI_W];
                out_tag_reg <= tag_a_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_rd    = out_rd_reg;
    assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_grev_pipe.sv
// Directed testbench for grev_pipe: a 32-bit and a 64-bit instance share the
// clock and reset. Expected results are hand-computed constants.
module tb_grev_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // 32-bit instance signals.
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic        in_op32 = 1'b0;
    logic [31:0] in_rs1_32 = '0;
    logic [4:0]  in_rs2_32 = '0;
    logic [3:0]  in_tag32 = '0;
    logic        out_valid32;
    logic        out_ready32 = 1'b1;
    logic [31:0] out_rd32;
    logic [3:0]  out_tag32;

    // 64-bit instance signals.
    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic        in_op64 = 1'b0;
    logic [63:0] in_rs1_64 = '0;
    logic [5:0]  in_rs2_64 = '0;
    logic [3:0]  in_tag64 = '0;
    logic        out_valid64;
    logic        out_ready64 = 1'b1;
    logic [63:0] out_rd64;
    logic [3:0]  out_tag64;

    int n_asserts = 0;
    int n_fail    = 0;

    // 32-bit directed vectors: op (0=GREV, 1=GORC), rs1, rs2, expected rd.
    logic        v_op  [0:11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] v_rs1 [0:11] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h00010080,
                                  32'h00000001, 32'h12345678, 32'h12345678, 32'h12345678,
                                  32'h12345678, 32'h00000001, 32'h00000001, 32'h80000000};
    logic [4:0]  v_rs2 [0:11] = '{5'd31, 5'd24, 5'd0, 5'd7, 5'd31, 5'd1, 5'd4, 5'd8,
                                  5'd16, 5'd0, 5'd3, 5'd16};
    logic [31:0] v_exp [0:11] = '{32'h1E6A2C48, 32'h78563412, 32'h12345678, 32'h00FF00FF,
                                  32'hFFFFFFFF, 32'h2138A9B4, 32'h21436587, 32'h34127856,
                                  32'h56781234, 32'h00000001, 32'h0000000F, 32'h80008000};

    grev_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_op     (in_op32),
        .in_rs1    (in_rs1_32),
        .in_rs2    (in_rs2_32),
        .in_tag    (in_tag32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_rd    (out_rd32),
        .out_tag   (out_tag32)
    );

    grev_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_op     (in_op64),
        .in_rs1    (in_rs1_64),
        .in_rs2    (in_rs2_64),
        .in_tag    (in_tag64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_rd    (out_rd64),
        .out_tag   (out_tag64)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive32(input int idx, input logic [3:0] tag);
        in_valid32 = 1'b1;
        in_op32    = v_op[idx];
        in_rs1_32  = v_rs1[idx];
        in_rs2_32  = v_rs2[idx];
        in_tag32   = tag;
    endtask

    // Single 32-bit operation: accept, confirm no early result, check result.
    task automatic run32(input int idx, input logic [3:0] tag);
        drive32(idx, tag);
        check($sformatf("v%0d in_ready", idx), {63'd0, in_ready32}, 64'd1);
        tick();
        in_valid32 = 1'b0;
        check($sformatf("v%0d not_early", idx), {63'd0, out_valid32}, 64'd0);
        tick();
        check($sformatf("v%0d out_valid", idx), {63'd0, out_valid32}, 64'd1);
        check($sformatf("v%0d out_rd", idx), {32'd0, out_rd32}, {32'd0, v_exp[idx]});
        check($sformatf("v%0d out_tag", idx), {60'd0, out_tag32}, {60'd0, tag});
        tick();
    endtask

    task automatic run64(input string name, input logic op, input logic [63:0] rs1,
                         input logic [5:0] rs2, input logic [63:0] exp, input logic [3:0] tag);
        in_valid64 = 1'b1;
        in_op64    = op;
        in_rs1_64  = rs1;
        in_rs2_64  = rs2;
        in_tag64   = tag;
        tick();
        in_valid64 = 1'b0;
        tick();
        check({name, " out_valid"}, {63'd0, out_valid64}, 64'd1);
        check({name, " out_rd"}, out_rd64, exp);
        check({name, " out_tag"}, {60'd0, out_tag64}, {60'd0, tag});
        tick();
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst out_valid32", {63'd0, out_valid32}, 64'd0);
        check("rst out_rd32", {32'd0, out_rd32}, 64'd0);
        check("rst out_tag32", {60'd0, out_tag32}, 64'd0);
        check("rst in_ready32", {63'd0, in_ready32}, 64'd1);
        check("rst out_valid64", {63'd0, out_valid64}, 64'd0);
        reset = 1'b0;
        check("post_rst in_ready32", {63'd0, in_ready32}, 64'd1);
        tick();

        // Directed single-operation vectors on the 32-bit instance.
        for (int i = 0; i < 12; i++) begin
            run32(i, 4'(i));
        end

        // Invalid inputs are ignored.
        in_valid32 = 1'b0;
        in_rs1_32  = 32'hDEADBEEF;
        in_rs2_32  = 5'd31;
        tick();
        tick();
        check("idle out_valid", {63'd0, out_valid32}, 64'd0);

        // 64-bit instance.
        run64("x64 rev8", 1'b0, 64'h0123456789ABCDEF, 6'd56, 64'hEFCDAB8967452301, 4'd1);
        run64("x64 swap32", 1'b0, 64'h0123456789ABCDEF, 6'd32, 64'h89ABCDEF01234567, 4'd2);
        run64("x64 rev", 1'b0, 64'h0123456789ABCDEF, 6'd63, 64'hF7B3D591E6A2C480, 4'd3);

        // Back-to-back stream of 8 ops, tags 0..7, out_ready held high.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive32(c, 4'(c));
            end else begin
                in_valid32 = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("stream%0d out_valid", c - 1), {63'd0, out_valid32}, 64'd1);
                check($sformatf("stream%0d out_tag", c - 1), {60'd0, out_tag32}, 64'(c - 1));
                check($sformatf("stream%0d out_rd", c - 1), {32'd0, out_rd32}, {32'd0, v_exp[c - 1]});
            end
        end
        check("stream end out_valid", {63'd0, out_valid32}, 64'd0);

        // Backpressure: three ops offered while the consumer stalls.
        out_ready32 = 1'b0;
        drive32(1, 4'd1);
        check("bp accept0 in_ready", {63'd0, in_ready32}, 64'd1);
        tick();
        drive32(3, 4'd2);
        check("bp accept1 in_ready", {63'd0, in_ready32}, 64'd1);
        tick();
        drive32(5, 4'd3);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("bp stall%0d in_ready", s), {63'd0, in_ready32}, 64'd0);
            check($sformatf("bp stall%0d out_valid", s), {63'd0, out_valid32}, 64'd1);
            check($sformatf("bp stall%0d out_rd", s), {32'd0, out_rd32}, {32'd0, v_exp[1]});
            check($sformatf("bp stall%0d out_tag", s), {60'd0, out_tag32}, 64'd1);
            tick();
        end
        out_ready32 = 1'b1;
        #1;
        check("bp release in_ready", {63'd0, in_ready32}, 64'd1);
        tick();
        in_valid32 = 1'b0;
        check("bp out1 tag", {60'd0, out_tag32}, 64'd2);
        check("bp out1 rd", {32'd0, out_rd32}, {32'd0, v_exp[3]});
        tick();
        check("bp out2 valid", {63'd0, out_valid32}, 64'd1);
        check("bp out2 tag", {60'd0, out_tag32}, 64'd3);
        check("bp out2 rd", {32'd0, out_rd32}, {32'd0, v_exp[5]});
        tick();
        check("bp drained", {63'd0, out_valid32}, 64'd0);

        // Reset with two operations in flight.
        drive32(0, 4'd9);
        tick();
        drive32(4, 4'd10);
        tick();
        in_valid32 = 1'b0;
        check("mid pre-reset valid", {63'd0, out_valid32}, 64'd1);
        reset = 1'b1;
        #1;
        check("mid reset out_valid", {63'd0, out_valid32}, 64'd0);
        check("mid reset in_ready", {63'd0, in_ready32}, 64'd1);
        tick();
        reset = 1'b0;
        tick();
        check("post reset stale0", {63'd0, out_valid32}, 64'd0);
        tick();
        check("post reset stale1", {63'd0, out_valid32}, 64'd0);
        run32(7, 4'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
